// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 datapath.
// Holds the sample-rate, bank/operator geometry and the operator slot
// sequencer state type used by operator_slot_sequencer.
package opl3_pkg;

   localparam int DAC_OVERSAMPLE         = 256;
   localparam int NUM_BANKS              = 2;
   localparam int NUM_OPERATORS_PER_BANK = 18;
   localparam int BANK_NUM_WIDTH         = 1;
   localparam int OP_NUM_WIDTH           = 5;

   localparam int OP_SLOT_CYCLES   = 6;
   localparam int SLOT_CYCLE_WIDTH = $clog2(OP_SLOT_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, MIX} op_seq_state_t;

endpackage

// File: rtl/sample_clk_gen.sv
// Sample-rate enable generator.
// A free-running counter 0..DAC_OVERSAMPLE-1 (not gated by anything but
// reset); sample_clk_en is a registered one-cycle pulse while the counter
// holds DAC_OVERSAMPLE-1.
// Ports:
//   clk           in  master clock
//   reset         in  synchronous, active-high
//   sample_clk_en out one pulse per sample period
module sample_clk_gen
   import opl3_pkg::*;
#(
   parameter int DAC_OVERSAMPLE = opl3_pkg::DAC_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   output logic sample_clk_en
);

   localparam int CW = $clog2(DAC_OVERSAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DAC_OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sample_clk_en_q, sample_clk_en_d;

   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      // Decoded from the next count so the pulse lines up with the counter value.
      sample_clk_en_d = (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q           <= '0;
         sample_clk_en_q <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         sample_clk_en_q <= sample_clk_en_d;
      end
   end

   assign sample_clk_en = sample_clk_en_q;

endmodule

// File: rtl/operator_slot_sequencer.sv
// Time-division scheduler for the shared operator datapath.
// On each sample tick (when enabled) walks bank 0 ops 0..N-1 then bank 1
// ops 0..N-1, each slot OP_SLOT_CYCLES clocks, then pulses mix_start.
// Ports:
//   clk, reset     master clock, synchronous active-high reset
//   enable         permits starting a new frame on a tick
//   op_ready       pipeline can accept a new slot (sampled at slot start only)
//   sample_clk_en  one-cycle pulse per sample period
//   bank_num/op_num current slot address for the operator pipeline
//   op_start       first cycle of a slot
//   op_active      slot in progress (low while stalled)
//   slot_cycle     cycle index within the slot
//   mix_start      one-cycle pulse after the final slot
//   overrun        sticky: tick arrived while a frame was running
module operator_slot_sequencer
   import opl3_pkg::*;
#(
   parameter int DAC_OVERSAMPLE         = opl3_pkg::DAC_OVERSAMPLE,
   parameter int OP_SLOT_CYCLES         = opl3_pkg::OP_SLOT_CYCLES,
   parameter int NUM_BANKS              = opl3_pkg::NUM_BANKS,
   parameter int NUM_OPERATORS_PER_BANK = opl3_pkg::NUM_OPERATORS_PER_BANK
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              op_ready,
   output logic                              sample_clk_en,
   output logic [BANK_NUM_WIDTH-1:0]         bank_num,
   output logic [OP_NUM_WIDTH-1:0]           op_num,
   output logic                              op_start,
   output logic                              op_active,
   output logic [$clog2(OP_SLOT_CYCLES)-1:0] slot_cycle,
   output logic                              mix_start,
   output logic                              overrun
);

   localparam int SCW = $clog2(OP_SLOT_CYCLES);
   localparam logic [SCW-1:0]            LAST_CYCLE = SCW'(OP_SLOT_CYCLES - 1);
   localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP    = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
   localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK  = BANK_NUM_WIDTH'(NUM_BANKS - 1);

   if (NUM_BANKS * NUM_OPERATORS_PER_BANK * OP_SLOT_CYCLES + 2 > DAC_OVERSAMPLE) begin : g_cfg_check
      $error("operator_slot_sequencer: frame does not fit in one sample period");
   end

   op_seq_state_t                 state_q, state_d;
   logic [BANK_NUM_WIDTH-1:0]     bank_q, bank_d;
   logic [OP_NUM_WIDTH-1:0]       op_q, op_d;
   logic [SCW-1:0]                slot_cycle_q, slot_cycle_d;
   logic                          op_start_q, op_start_d;
   logic                          op_active_q, op_active_d;
   logic                          mix_start_q, mix_start_d;
   logic                          overrun_q, overrun_d;

   sample_clk_gen #(
      .DAC_OVERSAMPLE(DAC_OVERSAMPLE)
   ) u_sample_clk_gen (
      .clk          (clk),
      .reset        (reset),
      .sample_clk_en(sample_clk_en)
   );

   // Outputs are registered, so the slot-start decision (op_ready) is taken
   // on the edge that enters the slot's first cycle. In RUN, op_active_q=0
   // marks a stalled slot start that is re-evaluated every cycle.
   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      op_d         = op_q;
      slot_cycle_d = slot_cycle_q;
      op_start_d   = 1'b0;
      op_active_d  = 1'b0;
      mix_start_d  = 1'b0;
      overrun_d    = overrun_q | (sample_clk_en && (state_q != IDLE));

      case (state_q)
         IDLE: begin
            if (sample_clk_en && enable) begin
               state_d      = RUN;
               bank_d       = '0;
               op_d         = '0;
               slot_cycle_d = '0;
               op_start_d   = op_ready;
               op_active_d  = op_ready;
            end
         end
         RUN: begin
            if (!op_active_q) begin
               op_start_d  = op_ready;
               op_active_d = op_ready;
            end else if (slot_cycle_q != LAST_CYCLE) begin
               slot_cycle_d = slot_cycle_q + 1'b1;
               op_active_d  = 1'b1;
            end else begin
               slot_cycle_d = '0;
               if (op_q != LAST_OP) begin
                  op_d        = op_q + 1'b1;
                  op_start_d  = op_ready;
                  op_active_d = op_ready;
               end else if (bank_q != LAST_BANK) begin
                  op_d        = '0;
                  bank_d      = bank_q + 1'b1;
                  op_start_d  = op_ready;
                  op_active_d = op_ready;
               end else begin
                  state_d     = MIX;
                  op_d        = '0;
                  bank_d      = '0;
                  mix_start_d = 1'b1;
               end
            end
         end
         MIX: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bank_q       <= '0;
         op_q         <= '0;
         slot_cycle_q <= '0;
         op_start_q   <= 1'b0;
         op_active_q  <= 1'b0;
         mix_start_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         op_q         <= op_d;
         slot_cycle_q <= slot_cycle_d;
         op_start_q   <= op_start_d;
         op_active_q  <= op_active_d;
         mix_start_q  <= mix_start_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bank_num   = bank_q;
   assign op_num     = op_q;
   assign slot_cycle = slot_cycle_q;
   assign op_start   = op_start_q;
   assign op_active  = op_active_q;
   assign mix_start  = mix_start_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_operator_slot_sequencer.sv
// Self-checking bench for operator_slot_sequencer: expected op_start/mix_start
// events are queued when each frame's stimulus is planned and compared as the
// DUT produces them; tick and overrun are checked against closed-form times.
module tb_operator_slot_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       op_ready = 1'b1;
   logic       sample_clk_en;
   logic [0:0] bank_num;
   logic [4:0] op_num;
   logic       op_start;
   logic       op_active;
   logic [2:0] slot_cycle;
   logic       mix_start;
   logic       overrun;

   operator_slot_sequencer #(
      .DAC_OVERSAMPLE(256),
      .OP_SLOT_CYCLES(6),
      .NUM_BANKS(2),
      .NUM_OPERATORS_PER_BANK(18)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .op_ready     (op_ready),
      .sample_clk_en(sample_clk_en),
      .bank_num     (bank_num),
      .op_num       (op_num),
      .op_start     (op_start),
      .op_active    (op_active),
      .slot_cycle   (slot_cycle),
      .mix_start    (mix_start),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit mix;
      int bank;
      int op;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_pass = 0;
   int  cyc = 0;
   int  ov_at = 0;
   bit  mon_on = 1'b0;

   // cycle index: 0 is the first cycle after the last reset edge
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      int g;
      g = 0;
      while (cyc < n) begin
         step();
         g++;
         if (g > 4000) begin
            chk("wait_bound", cyc, n);
            break;
         end
      end
   endtask

   // Queue one frame: tick at t, optional stall of l cycles before slot s.
   task automatic plan(input int t, input int s, input int l);
      ev_t e;
      for (int k = 0; k < 36; k++) begin
         e.mix  = 1'b0;
         e.bank = k / 18;
         e.op   = k % 18;
         e.cyc  = t + 1 + 6 * k + ((s >= 0 && k >= s) ? l : 0);
         exp_q.push_back(e);
      end
      e.mix  = 1'b1;
      e.bank = 0;
      e.op   = 0;
      e.cyc  = t + 217 + ((s >= 0) ? l : 0);
      exp_q.push_back(e);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_sample_clk_en"}, int'(sample_clk_en), 0);
      chk({pfx, "_op_start"},      int'(op_start), 0);
      chk({pfx, "_op_active"},     int'(op_active), 0);
      chk({pfx, "_mix_start"},     int'(mix_start), 0);
      chk({pfx, "_overrun"},       int'(overrun), 0);
      chk({pfx, "_bank_num"},      int'(bank_num), 0);
      chk({pfx, "_op_num"},        int'(op_num), 0);
      chk({pfx, "_slot_cycle"},    int'(slot_cycle), 0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         ev_t e;
         if (sample_clk_en || (cyc % 256 == 255))
            chk("tick", int'(sample_clk_en), (cyc % 256 == 255) ? 1 : 0);
         chk("overrun", int'(overrun), (ov_at != 0 && cyc >= ov_at) ? 1 : 0);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missed_event", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (op_start) begin
            if (exp_q.size() == 0) chk("extra_op_start", cyc, -1);
            else begin
               e = exp_q.pop_front();
               chk("start_kind", 0, int'(e.mix));
               chk("start_cyc", cyc, e.cyc);
               chk("start_bank", int'(bank_num), e.bank);
               chk("start_op", int'(op_num), e.op);
               chk("start_slot_cycle", int'(slot_cycle), 0);
               chk("start_op_active", int'(op_active), 1);
            end
         end
         if (mix_start) begin
            if (exp_q.size() == 0) chk("extra_mix_start", cyc, -1);
            else begin
               e = exp_q.pop_front();
               chk("mix_kind", 1, int'(e.mix));
               chk("mix_cyc", cyc, e.cyc);
               chk("mix_bank", int'(bank_num), 0);
               chk("mix_op", int'(op_num), 0);
               chk("mix_op_active", int'(op_active), 0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      enable   = 1'b1;
      op_ready = 1'b1;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_all_zero("reset");
      mon_on = 1'b1;

      // A: plain frame on the first tick
      plan(255, -1, 0);
      // B: 10-cycle stall at slot (0,5)
      wait_until(300);
      plan(511, 5, 10);
      wait_until(511 + 30);
      op_ready = 1'b0;
      repeat (10) step();
      op_ready = 1'b1;

      // C: op_ready toggled only mid-slot, timing unaffected
      wait_until(700);
      plan(767, -1, 0);
      wait_until(767);
      repeat (217) begin
         op_ready = ((cyc + 1 - 768) % 6 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         step();
      end
      op_ready = 1'b1;

      // D: 50-cycle stall at frame start overruns into the next tick
      wait_until(1000);
      plan(1023, 0, 50);
      ov_at = 1280;
      wait_until(1023);
      op_ready = 1'b0;
      repeat (50) step();
      op_ready = 1'b1;

      // E: tick 1279 dropped; next frame on 1535, enable dropped in slot (1,3)
      wait_until(1400);
      plan(1535, -1, 0);
      wait_until(1665);
      enable = 1'b0;
      wait_until(2100);
      enable = 1'b1;

      // F: resumes on tick 2303; reset during slot (0,9)
      plan(2303, -1, 0);
      wait_until(2360);
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      ov_at = 0;
      chk("post_reset_cyc", cyc, 0);
      chk_all_zero("midreset");

      // G: next tick 256 cycles after reset
      plan(255, -1, 0);
      wait_until(480);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
